// File: rtl/cell_exit_if.sv
// Handshake bundle between the per-cell output heads, the exit arbiter and the pair exit FIFO.
// The master modport is the arbiter side; the slave modport is the cells/FIFO environment.
interface cell_exit_if #(
   parameter int N_CELL = 27,
   parameter int REC_W  = 97,
   parameter int SRC_W  = 5
);
   logic [N_CELL-1:0]       i_req_valid;
   logic [N_CELL*REC_W-1:0] i_req_data;
   logic [N_CELL-1:0]       o_req_grant;
   logic                    o_pair_valid;
   logic [2*REC_W-1:0]      o_pair_data;
   logic [1:0]              o_pair_mask;
   logic [SRC_W-1:0]        o_pair_src0;
   logic [SRC_W-1:0]        o_pair_src1;
   logic                    i_pair_ready;
   logic                    i_clear;
   logic [31:0]             o_rec_count;
   logic                    o_idle;

   modport master (
      input  i_req_valid, i_req_data, i_pair_ready, i_clear,
      output o_req_grant, o_pair_valid, o_pair_data, o_pair_mask,
             o_pair_src0, o_pair_src1, o_rec_count, o_idle
   );

   modport slave (
      output i_req_valid, i_req_data, i_pair_ready, i_clear,
      input  o_req_grant, o_pair_valid, o_pair_data, o_pair_mask,
             o_pair_src0, o_pair_src1, o_rec_count, o_idle
   );
endinterface

// File: rtl/cell_exit_arbiter.sv
// Work-conserving round-robin arbiter: pops up to two cell heads per cycle into a
// registered output pair, honouring backpressure from the pair exit FIFO.
module cell_exit_arbiter #(
   parameter int N_CELL = 27,
   parameter int REC_W  = 97,
   parameter int SRC_W  = 5
) (
   input logic        clk,
   input logic        rst,
   cell_exit_if.master bus
);
   logic [SRC_W-1:0]   ptr;
   logic               pair_valid;
   logic [2*REC_W-1:0] pair_data;
   logic [1:0]         pair_mask;
   logic [SRC_W-1:0]   pair_src0;
   logic [SRC_W-1:0]   pair_src1;
   logic [31:0]        rec_count;

   logic               load;
   logic               have0;
   logic               have1;
   logic [SRC_W-1:0]   pick0;
   logic [SRC_W-1:0]   pick1;
   logic [SRC_W-1:0]   last_pick;
   logic [SRC_W-1:0]   idx;
   int                 pos;

   assign load      = !pair_valid || bus.i_pair_ready;
   assign last_pick = have1 ? pick1 : pick0;

   // Scan requesters starting at ptr with wrap; first two hits become the pair.
   always_comb begin
      have0 = 1'b0;
      have1 = 1'b0;
      pick0 = '0;
      pick1 = '0;
      idx   = '0;
      pos   = 0;
      for (int i = 0; i < N_CELL; i++) begin
         pos = int'(ptr) + i;
         if (pos >= N_CELL) pos = pos - N_CELL;
         idx = SRC_W'(pos);
         if (bus.i_req_valid[idx]) begin
            if (!have0) begin
               have0 = 1'b1;
               pick0 = idx;
            end else if (!have1) begin
               have1 = 1'b1;
               pick1 = idx;
            end
         end
      end
   end

   always_comb begin
      bus.o_req_grant = '0;
      if (!rst && load && have0) begin
         bus.o_req_grant[pick0] = 1'b1;
         if (have1) bus.o_req_grant[pick1] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= '0;
         pair_valid <= 1'b0;
         pair_data  <= '0;
         pair_mask  <= '0;
         pair_src0  <= '0;
         pair_src1  <= '0;
         rec_count  <= '0;
      end else begin
         // Clear takes priority over a same-cycle acceptance.
         if (bus.i_clear)
            rec_count <= '0;
         else if (pair_valid && bus.i_pair_ready)
            rec_count <= rec_count + 32'(pair_mask[0]) + 32'(pair_mask[1]);

         if (load) begin
            if (have0) begin
               pair_valid                <= 1'b1;
               pair_src0                 <= pick0;
               pair_data[0 +: REC_W]     <= bus.i_req_data[int'(pick0)*REC_W +: REC_W];
               if (have1) begin
                  pair_mask                 <= 2'b11;
                  pair_src1                 <= pick1;
                  pair_data[REC_W +: REC_W] <= bus.i_req_data[int'(pick1)*REC_W +: REC_W];
               end else begin
                  pair_mask                 <= 2'b01;
                  pair_src1                 <= '0;
                  pair_data[REC_W +: REC_W] <= '0;
               end
               if (int'(last_pick) == N_CELL - 1)
                  ptr <= '0;
               else
                  ptr <= last_pick + 1'b1;
            end else begin
               pair_valid <= 1'b0;
            end
         end
      end
   end

   assign bus.o_pair_valid = pair_valid;
   assign bus.o_pair_data  = pair_data;
   assign bus.o_pair_mask  = pair_mask;
   assign bus.o_pair_src0  = pair_src0;
   assign bus.o_pair_src1  = pair_src1;
   assign bus.o_rec_count  = rec_count;
   assign bus.o_idle       = !(|bus.i_req_valid) && !pair_valid;
endmodule

// File: tb/tb_cell_exit_arbiter.sv
// Directed bench for cell_exit_arbiter: queue-based round-robin model checked every
// cycle, plus literal expectations for the hand-worked scenarios.
module tb_cell_exit_arbiter;
   localparam int N = 27;
   localparam int W = 97;
   localparam int S = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ready = 1'b1;
   logic clear = 1'b0;
   always #5 clk = ~clk;

   cell_exit_if #(.N_CELL(N), .REC_W(W), .SRC_W(S)) bus ();
   cell_exit_arbiter #(.N_CELL(N), .REC_W(W), .SRC_W(S)) dut (.clk(clk), .rst(rst), .bus(bus));

   int pend[N];
   int seq[N];
   int total = 0;
   int bad = 0;
   bit started = 1'b0;

   function automatic logic [W-1:0] rec(input int k, input int s);
      return {32'hC0DE0000 + 32'(s), 32'(k), 33'(s * 7 + k)};
   endfunction

   always_comb begin
      bus.i_req_valid = '0;
      bus.i_req_data  = '0;
      for (int k = 0; k < N; k++) begin
         bus.i_req_valid[k]        = pend[k] > 0;
         bus.i_req_data[k*W +: W]  = rec(k, seq[k]);
      end
   end
   assign bus.i_pair_ready = ready;
   assign bus.i_clear      = clear;

   task automatic cmp(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model state.
   int m_ptr = 0;
   bit m_valid = 1'b0;
   logic [1:0] m_mask = '0;
   logic [W-1:0] m_d0 = '0;
   logic [W-1:0] m_d1 = '0;
   int m_s0 = 0;
   int m_s1 = 0;
   logic [31:0] m_count = '0;

   function automatic void rr(input logic [N-1:0] v, input int p, output int a, output int b);
      int q[$];
      for (int i = 0; i < N; i++)
         if (v[(p + i) % N]) q.push_back((p + i) % N);
      a = (q.size() > 0) ? q[0] : -1;
      b = (q.size() > 1) ? q[1] : -1;
   endfunction

   function automatic logic [N-1:0] exp_grant();
      logic [N-1:0] g = '0;
      int a, b;
      if (rst || !(!m_valid || ready)) return g;
      rr(bus.i_req_valid, m_ptr, a, b);
      if (a >= 0) g[a] = 1'b1;
      if (b >= 0) g[b] = 1'b1;
      return g;
   endfunction

   always @(posedge clk) begin
      int a, b;
      if (rst) begin
         m_ptr = 0; m_valid = 1'b0; m_mask = '0; m_d0 = '0; m_d1 = '0;
         m_s0 = 0; m_s1 = 0; m_count = '0;
      end else begin
         if (clear) m_count = '0;
         else if (m_valid && ready) m_count = m_count + 32'(m_mask[0]) + 32'(m_mask[1]);
         if (!m_valid || ready) begin
            rr(bus.i_req_valid, m_ptr, a, b);
            if (a >= 0) begin
               m_valid = 1'b1;
               m_s0 = a;
               m_d0 = bus.i_req_data[a*W +: W];
               if (b >= 0) begin
                  m_mask = 2'b11; m_s1 = b; m_d1 = bus.i_req_data[b*W +: W];
               end else begin
                  m_mask = 2'b01; m_s1 = 0; m_d1 = '0;
               end
               m_ptr = (((b >= 0) ? b : a) + 1) % N;
            end else begin
               m_valid = 1'b0;
            end
         end
      end
      started = 1'b1;
   end

   // Upstream cell heads: each grant pops one record.
   always @(posedge clk) begin
      logic [N-1:0] g;
      g = bus.o_req_grant;
      #1;
      for (int k = 0; k < N; k++)
         if (g[k] && pend[k] > 0) begin
            pend[k] = pend[k] - 1;
            seq[k]  = seq[k] + 1;
         end
   end

   always @(negedge clk) begin
      if (started) begin
         cmp("grant", bus.o_req_grant, exp_grant());
         cmp("pair_valid", bus.o_pair_valid, m_valid);
         if (m_valid) begin
            cmp("pair_mask", bus.o_pair_mask, m_mask);
            cmp("pair_src0", bus.o_pair_src0, m_s0);
            cmp("pair_src1", bus.o_pair_src1, m_s1);
            cmp("pair_data", bus.o_pair_data, {m_d1, m_d0});
         end
         cmp("rec_count", bus.o_rec_count, m_count);
         cmp("idle", bus.o_idle, (bus.i_req_valid == '0) && !m_valid);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < N; k++) begin pend[k] = 0; seq[k] = 0; end
      tick();
      tick();
      rst = 1'b0;
      cmp("lit_reset_valid", bus.o_pair_valid, 1'b0);
      cmp("lit_reset_count", bus.o_rec_count, 32'd0);

      // Single requester.
      pend[5] = 1;
      #1 cmp("lit_single_grant", bus.o_req_grant, 27'(1) << 5);
      tick();
      cmp("lit_single_valid", bus.o_pair_valid, 1'b1);
      cmp("lit_single_mask", bus.o_pair_mask, 2'b01);
      cmp("lit_single_src0", bus.o_pair_src0, 5);
      cmp("lit_single_data", bus.o_pair_data[W-1:0], rec(5, 0));
      cmp("lit_single_ptr", m_ptr, 6);
      tick();
      cmp("lit_single_count", bus.o_rec_count, 32'd1);

      // Wrap-around: walk ptr to 26 first.
      pend[25] = 1;
      tick();
      cmp("lit_wrap_pre_ptr", m_ptr, 26);
      pend[1] = 1; pend[26] = 1;
      tick();
      cmp("lit_wrap_src0", bus.o_pair_src0, 26);
      cmp("lit_wrap_src1", bus.o_pair_src1, 1);
      cmp("lit_wrap_mask", bus.o_pair_mask, 2'b11);
      cmp("lit_wrap_ptr", m_ptr, 2);
      tick();
      cmp("lit_wrap_count", bus.o_rec_count, 32'd4);

      // Backpressure: pair (3,9) must hold while ready is low.
      pend[3] = 1; pend[9] = 1;
      tick();
      ready = 1'b0;
      pend[12] = 1;
      for (int i = 0; i < 4; i++) begin
         #1 cmp("lit_bp_grant", bus.o_req_grant, 27'd0);
         tick();
         cmp("lit_bp_src0", bus.o_pair_src0, 3);
         cmp("lit_bp_src1", bus.o_pair_src1, 9);
      end
      ready = 1'b1;
      #1 cmp("lit_bp_release_grant", bus.o_req_grant, 27'(1) << 12);
      tick();
      cmp("lit_bp_next_src0", bus.o_pair_src0, 12);
      cmp("lit_bp_count", bus.o_rec_count, 32'd6);

      // Clear colliding with a two-record acceptance.
      pend[7] = 1; pend[8] = 1;
      tick();
      cmp("lit_clr_pre_count", bus.o_rec_count, 32'd7);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      cmp("lit_clr_count", bus.o_rec_count, 32'd0);
      tick();
      cmp("lit_clr_idle", bus.o_idle, 1'b1);

      // All cells valid from reset: record i must come from cell i mod 27.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < N; k++) pend[k] = 100;
      for (int j = 0; j < N; j++) begin
         tick();
         cmp("lit_rr_src0", bus.o_pair_src0, (2 * j) % N);
         cmp("lit_rr_src1", bus.o_pair_src1, (2 * j + 1) % N);
         cmp("lit_rr_mask", bus.o_pair_mask, 2'b11);
      end

      // Reset while a pair is held under backpressure.
      ready = 1'b0;
      tick();
      cmp("lit_hold_src0", bus.o_pair_src0, 25);
      rst = 1'b1;
      #1 cmp("lit_rst_grant_a", bus.o_req_grant, 27'd0);
      tick();
      cmp("lit_rst_valid", bus.o_pair_valid, 1'b0);
      cmp("lit_rst_mask", bus.o_pair_mask, 2'b00);
      cmp("lit_rst_src", {bus.o_pair_src1, bus.o_pair_src0}, 10'd0);
      cmp("lit_rst_data", bus.o_pair_data, '0);
      cmp("lit_rst_count", bus.o_rec_count, 32'd0);
      cmp("lit_rst_ptr", m_ptr, 0);
      ready = 1'b1;
      #1 cmp("lit_rst_grant_b", bus.o_req_grant, 27'd0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < N; k++) pend[k] = 0;
      tick();
      tick();
      cmp("lit_final_idle", bus.o_idle, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
